// File: rtl/muxn_reg.sv
// ---------------------------------------------------------------------------
// muxn_reg -- registered N-channel multiplexer with blanked channel switching
//
// Selects one of NCH packed input channels onto a registered output Y. A
// change of the selected channel is requested with SEL_REQ/SEL_IN. When the
// request names a different valid channel, the output is blanked (driven to
// its deasserted level with Y_VLD low) for GAP cycles plus one SWITCH cycle
// before the new channel appears. This keeps downstream logic from ever
// seeing a sample that mixes two channels.
//
// Parameters
//   WIDTH  bits per data channel (1..64)
//   NCH    number of input channels (2..16)
//   GAP    blanking cycles inserted on a channel change (1..15)
//   INV    1: Y is the inverted channel and blanks to all-ones
//          0: Y is the channel as-is and blanks to all-zeros
//   SW     select width, max(1, clog2(NCH))
//
// Ports
//   CLK      in   rising-edge clock
//   RST      in   synchronous active-high reset
//   D        in   packed channel data, channel k at [k*WIDTH +: WIDTH]
//   SEL_REQ  in   select-change request, qualified every cycle
//   SEL_IN   in   requested channel index
//   SEL_ACK  out  one-cycle pulse: request accepted
//   SEL_ERR  out  one-cycle pulse: request rejected (index >= NCH)
//   BUSY     out  high while blanking/switching; requests are ignored
//   S_CUR    out  channel currently driving Y
//   Y        out  registered mux output
//   Y_VLD    out  high when Y carries channel data
// ---------------------------------------------------------------------------
module muxn_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int GAP   = 2,
    parameter int INV   = 1,
    localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic                 SEL_REQ,
    input  logic [SW-1:0]        SEL_IN,
    output logic                 SEL_ACK,
    output logic                 SEL_ERR,
    output logic                 BUSY,
    output logic [SW-1:0]        S_CUR,
    output logic [WIDTH-1:0]     Y,
    output logic                 Y_VLD
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BLANK  = 2'd1,
        SWITCH = 2'd2
    } state_e;

    // Level Y rests at while no channel is being passed through.
    localparam logic [WIDTH-1:0] BLANK_LVL = (INV != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    // The channel table is padded up to a power of two so that any SW-bit
    // index addresses a real entry; only valid indices are ever latched.
    localparam int NSLOT = 1 << SW;

    localparam logic [3:0] GAP_M1 = 4'(GAP - 1);

    // Applies the output polarity to a selected channel sample.
    function automatic logic [WIDTH-1:0] drive_level(input logic [WIDTH-1:0] v);
        return (INV != 0) ? ~v : v;
    endfunction

    state_e           state_q;
    logic [SW-1:0]    s_cur_q;
    logic [SW-1:0]    pend_q;
    logic [3:0]       cnt_q;
    logic             ack_q;
    logic             err_q;
    logic [WIDTH-1:0] y_q;
    logic             vld_q;

    logic [WIDTH-1:0] ch [NSLOT];
    logic [31:0]      sel_wide;
    logic             sel_ok_d;
    logic [WIDTH-1:0] y_run_d;

    genvar k;
    generate
        for (k = 0; k < NSLOT; k++) begin : g_ch
            if (k < NCH) begin : g_real
                assign ch[k] = D[k*WIDTH +: WIDTH];
            end else begin : g_pad
                assign ch[k] = {WIDTH{1'b0}};
            end
        end
    endgenerate

    // Range check is done at full 32-bit width so that a power-of-two NCH
    // can never flag an index as out of range.
    assign sel_wide = 32'(SEL_IN);
    assign sel_ok_d = (sel_wide < 32'(NCH));
    assign y_run_d  = drive_level(ch[s_cur_q]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            s_cur_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= BLANK_LVL;
            vld_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                RUN: begin
                    y_q   <= y_run_d;
                    vld_q <= 1'b1;
                    if (SEL_REQ) begin
                        if (!sel_ok_d) begin
                            err_q <= 1'b1;
                        end else begin
                            ack_q <= 1'b1;
                            // Re-selecting the live channel is acknowledged
                            // without disturbing the output.
                            if (SEL_IN != s_cur_q) begin
                                pend_q  <= SEL_IN;
                                cnt_q   <= GAP_M1;
                                state_q <= BLANK;
                            end
                        end
                    end
                end
                BLANK: begin
                    y_q   <= BLANK_LVL;
                    vld_q <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_q <= SWITCH;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SWITCH: begin
                    y_q     <= BLANK_LVL;
                    vld_q   <= 1'b0;
                    s_cur_q <= pend_q;
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign SEL_ACK = ack_q;
    assign SEL_ERR = err_q;
    assign BUSY    = (state_q != RUN);
    assign S_CUR   = s_cur_q;
    assign Y       = y_q;
    assign Y_VLD   = vld_q;

endmodule
